// File: rtl/commit_unit_if.sv
// Commit port between the reorder buffer and the commit unit.
// The ROB drives the packet fields; the commit unit answers with the stall.
interface commit_unit_if;
    logic        in_ready;
    logic [31:0] in_value;
    logic [31:0] in_miss_addr;
    logic [31:0] in_PC;
    logic [4:0]  in_rd;
    logic [2:0]  in_exception;
    logic [2:0]  in_instr_type;
    logic        out_stall;

    modport master (
        output in_ready, in_value, in_miss_addr, in_PC, in_rd, in_exception, in_instr_type,
        input  out_stall
    );

    modport slave (
        input  in_ready, in_value, in_miss_addr, in_PC, in_rd, in_exception, in_instr_type,
        output out_stall
    );
endinterface

// File: rtl/commit_unit.sv
// In-order commit stage: register writeback, retirement count, exception entry and IRET,
// with a fixed ROB stall window after every flush.
//
// state   | meaning
// RUN     | commit packets accepted, out_stall low
// RECOVER | post-flush window, packets ignored, out_stall high
module commit_unit #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_2000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    commit_unit_if.slave cmt,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_rd,
    output logic [31:0] out_rf_value,
    output logic        out_flush,
    output logic        out_redirect,
    output logic [31:0] out_redirect_PC,
    output logic [31:0] out_rm0,
    output logic [31:0] out_rm1,
    output logic [2:0]  out_rm2,
    output logic        out_supervisor,
    output logic [31:0] out_retired
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic        rf_we_nxt, flush_nxt, redirect_nxt, sup_nxt, stall_nxt;
    logic [4:0]  rf_rd_nxt;
    logic [31:0] rf_value_nxt, redirect_pc_nxt, rm0_nxt, rm1_nxt, retired_nxt;
    logic [2:0]  rm2_nxt;

    logic [2:0]  cause;
    logic        is_iret, take_exc, writes_rf;

    // Reserved causes collapse to illegal; IRET from user mode is also illegal.
    assign cause     = (cmt.in_exception >= 3'd3) ? 3'd3 : cmt.in_exception;
    assign is_iret   = (cmt.in_instr_type == 3'd5);
    assign take_exc  = (cause != 3'd0) || (is_iret && !out_supervisor);
    assign writes_rf = (cmt.in_instr_type != 3'd3) && (cmt.in_instr_type != 3'd4);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rf_we_nxt       = 1'b0;
        rf_rd_nxt       = out_rf_rd;
        rf_value_nxt    = out_rf_value;
        flush_nxt       = 1'b0;
        redirect_nxt    = 1'b0;
        redirect_pc_nxt = out_redirect_PC;
        rm0_nxt         = out_rm0;
        rm1_nxt         = out_rm1;
        rm2_nxt         = out_rm2;
        sup_nxt         = out_supervisor;
        retired_nxt     = out_retired;
        case (state)
            RUN: begin
                if (cmt.in_ready) begin
                    if (take_exc) begin
                        rm0_nxt         = cmt.in_PC;
                        rm1_nxt         = cmt.in_miss_addr;
                        rm2_nxt         = (cause != 3'd0) ? cause : 3'd3;
                        sup_nxt         = 1'b1;
                        flush_nxt       = 1'b1;
                        redirect_nxt    = 1'b1;
                        redirect_pc_nxt = HANDLER_PC;
                        state_nxt       = RECOVER;
                        cnt_nxt         = CNT_LOAD;
                    end else if (is_iret) begin
                        sup_nxt         = 1'b0;
                        flush_nxt       = 1'b1;
                        redirect_nxt    = 1'b1;
                        redirect_pc_nxt = out_rm0;
                        retired_nxt     = out_retired + 32'd1;
                        state_nxt       = RECOVER;
                        cnt_nxt         = CNT_LOAD;
                    end else begin
                        retired_nxt = out_retired + 32'd1;
                        if (writes_rf && cmt.in_rd != 5'd0) begin
                            rf_we_nxt    = 1'b1;
                            rf_rd_nxt    = cmt.in_rd;
                            rf_value_nxt = cmt.in_value;
                        end
                    end
                end
            end
            RECOVER: begin
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = RUN;
        endcase
        stall_nxt = (state_nxt == RECOVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            cnt             <= '0;
            cmt.out_stall   <= 1'b0;
            out_rf_we       <= 1'b0;
            out_rf_rd       <= 5'd0;
            out_rf_value    <= 32'd0;
            out_flush       <= 1'b0;
            out_redirect    <= 1'b0;
            out_redirect_PC <= 32'd0;
            out_rm0         <= 32'd0;
            out_rm1         <= 32'd0;
            out_rm2         <= 3'd0;
            out_supervisor  <= 1'b1;
            out_retired     <= 32'd0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            cmt.out_stall   <= stall_nxt;
            out_rf_we       <= rf_we_nxt;
            out_rf_rd       <= rf_rd_nxt;
            out_rf_value    <= rf_value_nxt;
            out_flush       <= flush_nxt;
            out_redirect    <= redirect_nxt;
            out_redirect_PC <= redirect_pc_nxt;
            out_rm0         <= rm0_nxt;
            out_rm1         <= rm1_nxt;
            out_rm2         <= rm2_nxt;
            out_supervisor  <= sup_nxt;
            out_retired     <= retired_nxt;
        end
    end
endmodule

// File: tb/tb_commit_unit.sv
// Vector table of commit packets with hand-computed outputs, plus a reset-during-recovery
// sequence.
module tb_commit_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        rf_we, flush, redirect, supervisor;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value, redirect_pc, rm0, rm1, retired;
    logic [2:0]  rm2;

    int checks = 0;
    int errors = 0;

    commit_unit_if cif ();

    commit_unit #(.HANDLER_PC(32'h0000_2000), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmt             (cif),
        .out_rf_we       (rf_we),
        .out_rf_rd       (rf_rd),
        .out_rf_value    (rf_value),
        .out_flush       (flush),
        .out_redirect    (redirect),
        .out_redirect_PC (redirect_pc),
        .out_rm0         (rm0),
        .out_rm1         (rm1),
        .out_rm2         (rm2),
        .out_supervisor  (supervisor),
        .out_retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [2:0]  exc;
        logic [2:0]  typ;
        logic [31:0] pc;
        logic [31:0] miss;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        e_we;
        logic        e_flush;
        logic [31:0] e_rpc;
        logic        e_stall;
        logic [31:0] e_ret;
        logic        e_sup;
        logic [31:0] e_rm0;
        logic [31:0] e_rm1;
        logic [2:0]  e_rm2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rdy, logic [2:0] exc, logic [2:0] typ, logic [31:0] pc,
                                logic [31:0] miss, logic [4:0] rd, logic [31:0] val,
                                logic e_we, logic e_flush, logic [31:0] e_rpc, logic e_stall,
                                logic [31:0] e_ret, logic e_sup, logic [31:0] e_rm0,
                                logic [31:0] e_rm1, logic [2:0] e_rm2);
        vec_t v;
        v.rdy = rdy; v.exc = exc; v.typ = typ; v.pc = pc; v.miss = miss; v.rd = rd; v.val = val;
        v.e_we = e_we; v.e_flush = e_flush; v.e_rpc = e_rpc; v.e_stall = e_stall;
        v.e_ret = e_ret; v.e_sup = e_sup; v.e_rm0 = e_rm0; v.e_rm1 = e_rm1; v.e_rm2 = e_rm2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [2:0] exc, input logic [2:0] typ,
                         input logic [31:0] pc, input logic [31:0] miss, input logic [4:0] rd,
                         input logic [31:0] val);
        cif.in_ready      = rdy;
        cif.in_exception  = exc;
        cif.in_instr_type = typ;
        cif.in_PC         = pc;
        cif.in_miss_addr  = miss;
        cif.in_rd         = rd;
        cif.in_value      = val;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_stall"},    32'(cif.out_stall), 32'd0);
        chk({tag, "_we"},       32'(rf_we),         32'd0);
        chk({tag, "_flush"},    32'(flush),         32'd0);
        chk({tag, "_redirect"}, 32'(redirect),      32'd0);
        chk({tag, "_rf_rd"},    32'(rf_rd),         32'd0);
        chk({tag, "_rf_value"}, rf_value,           32'd0);
        chk({tag, "_rpc"},      redirect_pc,        32'd0);
        chk({tag, "_rm0"},      rm0,                32'd0);
        chk({tag, "_rm1"},      rm1,                32'd0);
        chk({tag, "_rm2"},      32'(rm2),           32'd0);
        chk({tag, "_sup"},      32'(supervisor),    32'd1);
        chk({tag, "_retired"},  retired,            32'd0);
    endtask

    initial begin
        // rdy exc typ pc miss rd val | we flush rpc stall retired sup rm0 rm1 rm2
        vecs.push_back(mk(1,0,0,32'h100,0,5,32'h11,            1,0,32'h0,0,3'd0+1,1,0,0,0));
        vecs.push_back(mk(1,0,0,32'h104,0,6,32'h22,            1,0,32'h0,0,2,1,0,0,0));
        vecs.push_back(mk(1,0,0,32'h108,0,0,32'h33,            0,0,32'h0,0,3,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h0,0,3,1,0,0,0));
        vecs.push_back(mk(1,2,2,32'h1040,32'hDEAD_0000,8,32'h44, 0,1,32'h2000,1,3,1,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,0,32'h10C,0,7,32'h77,            0,0,32'h2000,1,3,1,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,0,32'h10C,0,7,32'h77,            0,0,32'h2000,0,3,1,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,0,32'h10C,0,7,32'h77,            1,0,32'h2000,0,4,1,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,5,32'h3000,0,0,0,                0,1,32'h1040,1,5,0,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h1040,1,5,0,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h1040,0,5,0,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,3,32'h110,0,2,32'h5,             0,0,32'h1040,0,6,0,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,4,32'h114,0,3,32'h6,             0,0,32'h1040,0,7,0,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,1,32'h118,0,31,32'hCAFE,         1,0,32'h1040,0,8,0,32'h1040,32'hDEAD_0000,2));
        vecs.push_back(mk(1,0,5,32'h4000,32'h55,0,0,           0,1,32'h2000,1,8,1,32'h4000,32'h55,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h2000,1,8,1,32'h4000,32'h55,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h2000,0,8,1,32'h4000,32'h55,3));
        vecs.push_back(mk(1,6,0,32'h5000,32'h66,3,32'h1,       0,1,32'h2000,1,8,1,32'h5000,32'h66,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h2000,1,8,1,32'h5000,32'h66,3));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h2000,0,8,1,32'h5000,32'h66,3));
        vecs.push_back(mk(1,0,7,32'h120,0,9,32'h99,            1,0,32'h2000,0,9,1,32'h5000,32'h66,3));
        vecs.push_back(mk(1,1,2,32'h6000,32'h77,4,0,           0,1,32'h2000,1,9,1,32'h6000,32'h77,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h2000,1,9,1,32'h6000,32'h77,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,                       0,0,32'h2000,0,9,1,32'h6000,32'h77,1));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values("init");

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].exc, vecs[i].typ, vecs[i].pc, vecs[i].miss,
                  vecs[i].rd, vecs[i].val);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_we", i),       32'(rf_we),         32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_rf_rd", i),  32'(rf_rd),       32'(vecs[i].rd));
                chk($sformatf("v%0d_rf_val", i), rf_value,         vecs[i].val);
            end
            chk($sformatf("v%0d_flush", i),    32'(flush),         32'(vecs[i].e_flush));
            chk($sformatf("v%0d_redirect", i), 32'(redirect),      32'(vecs[i].e_flush));
            chk($sformatf("v%0d_rpc", i),      redirect_pc,        vecs[i].e_rpc);
            chk($sformatf("v%0d_stall", i),    32'(cif.out_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_retired", i),  retired,            vecs[i].e_ret);
            chk($sformatf("v%0d_sup", i),      32'(supervisor),    32'(vecs[i].e_sup));
            chk($sformatf("v%0d_rm0", i),      rm0,                vecs[i].e_rm0);
            chk($sformatf("v%0d_rm1", i),      rm1,                vecs[i].e_rm1);
            chk($sformatf("v%0d_rm2", i),      32'(rm2),           32'(vecs[i].e_rm2));
        end

        // Exception, then reset in the first recovery cycle with a packet also presented.
        drive(1, 2, 2, 32'h7000, 32'h88, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rr_stall_pre", 32'(cif.out_stall), 32'd1);
        chk("rr_rm0_pre",   rm0,                32'h7000);
        reset = 1'b1;
        drive(1, 0, 0, 32'h130, 0, 10, 32'hAB);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values("rr");
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rr_idle_stall", 32'(cif.out_stall), 32'd0);
        drive(1, 0, 0, 32'h134, 0, 4, 32'h4444);
        @(posedge clk);
        @(negedge clk);
        chk("rr_post_we",      32'(rf_we), 32'd1);
        chk("rr_post_rd",      32'(rf_rd), 32'd4);
        chk("rr_post_val",     rf_value,   32'h4444);
        chk("rr_post_retired", retired,    32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
